// File: rtl/reg_copy_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reg_copy_sequencer
// Purpose  : Bus-master sequencer copying one byte between bank registers and
//            the external port per COPY instruction (IDLE -> READ -> WRITE).
// Revision : 1.0 - initial release
// ============================================================================
module reg_copy_sequencer #(
    parameter int NREG = 6,
    parameter int W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [7:0]      instr_byte,
    output logic            instr_ready,
    output logic [NREG-1:0] load1_en,
    input  logic [W-1:0]    bus_in,
    input  logic [W-1:0]    ext_in_byte,
    output logic [NREG-1:0] save_en,
    output logic [W-1:0]    save_byte,
    output logic [W-1:0]    ext_out_byte,
    output logic            ext_out_valid,
    output logic            done,
    output logic            illegal,
    output logic [7:0]      copy_count
);

    localparam logic [2:0] C_EXT_CODE = 3'd6;
    localparam logic [1:0] C_OP_COPY  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     src_q, src_d;
    logic [2:0]     dst_q, dst_d;
    logic [W-1:0]   hold_q, hold_d;
    logic [W-1:0]   ext_out_q, ext_out_d;
    logic           ext_valid_q, ext_valid_d;
    logic           illegal_q, illegal_d;
    logic [7:0]     count_q, count_d;

    logic [2:0]     w_src;
    logic [2:0]     w_dst;
    logic           w_legal;

    assign w_src   = instr_byte[5:3];
    assign w_dst   = instr_byte[2:0];
    assign w_legal = (instr_byte[7:6] == C_OP_COPY)
                  && ((int'(w_src) < NREG) || (w_src == C_EXT_CODE))
                  && ((int'(w_dst) < NREG) || (w_dst == C_EXT_CODE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            hold_q      <= '0;
            ext_out_q   <= '0;
            ext_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            hold_q      <= hold_d;
            ext_out_q   <= ext_out_d;
            ext_valid_q <= ext_valid_d;
            illegal_q   <= illegal_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        hold_d      = hold_q;
        ext_out_d   = ext_out_q;
        ext_valid_d = 1'b0;
        illegal_d   = 1'b0;
        count_d     = count_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    if (w_legal) begin
                        src_d   = w_src;
                        dst_d   = w_dst;
                        state_d = S_READ;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                hold_d  = (src_q == C_EXT_CODE) ? ext_in_byte : bus_in;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (dst_q == C_EXT_CODE) begin
                    ext_out_d   = hold_q;
                    ext_valid_d = 1'b1;
                end
                count_d = count_q + 8'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Enables decode from registered state only, so reset drops them at once.
    always_comb begin
        load1_en = '0;
        save_en  = '0;
        for (int i = 0; i < NREG; i++) begin
            if ((state_q == S_READ) && (src_q == 3'(i)))
                load1_en[i] = 1'b1;
            if ((state_q == S_WRITE) && (dst_q == 3'(i)))
                save_en[i] = 1'b1;
        end
    end

    assign instr_ready   = (state_q == S_IDLE);
    assign done          = (state_q == S_WRITE);
    assign save_byte     = hold_q;
    assign ext_out_byte  = ext_out_q;
    assign ext_out_valid = ext_valid_q;
    assign illegal       = illegal_q;
    assign copy_count    = count_q;

endmodule
`default_nettype wire

// File: doc/reg_copy_sequencer.md
Name: reg_copy_sequencer

Overview:
- Bus-master controller for the register bank: it drives the enables of the 8-bit registers rather than being driven by them.
- Accepts one COPY instruction byte per valid/ready handshake.
- Asserts the source register's port-1 load enable so the source drives the shared bus, and captures the bus value into a holding register.
- Then asserts the destination register's save enable with the held byte. Source/destination code 6 maps to the external input/output port.

Parameters:
- NREG, 6, number of bank registers (codes 0..NREG-1); fixed ≤6 so codes 6/7 stay reserved.
- W, 8, data/bus width.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- instr_valid  input  1  instruction byte present.
- instr_byte  input  8  [7:6] opcode (2'b10 = COPY), [5:3] source code, [2:0] destination code.
- instr_ready  output  1  sequencer can accept an instruction.
- load1_en  output  NREG  one-hot port-1 load enables to bank registers.
- bus_in  input  W  resolved shared bus (bank tri-state port-1 outputs).
- ext_in_byte  input  W  external input port value (source code 6).
- save_en  output  NREG  one-hot save enables to bank registers.
- save_byte  output  W  data presented to all bank save inputs.
- ext_out_byte  output  W  external output port register (destination code 6).
- ext_out_valid  output  1  one-cycle pulse when ext_out_byte is updated.
- done  output  1  one-cycle pulse, transfer complete.
- illegal  output  1  one-cycle pulse, instruction rejected.
- copy_count  output  8  count of completed transfers, wraps 255→0.

Behaviour:
- States: IDLE, READ, WRITE. All outputs decode from registered state only; there is no combinational path from inputs to outputs.
- Reset (async, immediate):
  - state=IDLE; src/dst/hold regs=0.
  - load1_en=0, save_en=0, save_byte=0.
  - ext_out_byte=0, ext_out_valid=0, done=0, illegal=0, copy_count=0.
- instr_ready=1 only in IDLE. An instruction is accepted on a clk edge with instr_valid&&instr_ready.
- Legality: opcode==2'b10, src∈{0..NREG-1,6}, dst∈{0..NREG-1,6}.
  - Illegal on accept: stay IDLE; illegal=1 for the next cycle; no enables asserted; count unchanged.
  - Legal on accept: latch src and dst; go to READ.
- READ (1 cycle):
  - Bank source: load1_en[src]=1. Source 6: load1_en=0.
  - At the ending edge, hold <= (src==6 ? ext_in_byte : bus_in). Then go to WRITE.
- WRITE (1 cycle):
  - save_byte=hold throughout; save_byte holds its value outside WRITE too.
  - Bank destination: save_en[dst]=1, so the bank captures at the ending edge.
  - Destination 6: save_en=0; at the ending edge ext_out_byte<=hold, and ext_out_valid pulses in the following cycle.
  - done=1 during the WRITE cycle.
  - At the ending edge: copy_count<=copy_count+1 (mod 256); go to IDLE.
- Latency and throughput:
  - Accept edge E0 → READ in cycle 1 → WRITE in cycle 2 → IDLE and ready in cycle 3.
  - Back-to-back valid gives one transfer per 3 cycles.
- At most one bit of load1_en and one bit of save_en is ever high. Both are never high in the same cycle.
- src==dst is legal: the register rewrites its own value, count increments.
- 6→6 is legal: ext_in_byte is copied to ext_out_byte.
- instr_valid/instr_byte are ignored outside IDLE.
- Reset mid-READ or mid-WRITE:
  - The transfer is aborted; enables drop asynchronously.
  - No save occurs if rst is asserted before the WRITE ending edge.
  - done is not pulsed; the instruction is lost.

Test Plan:
- Reset, then instr 8'b10_000_011 with bank reg0=8'h5A → cycle1 load1_en=6'b000001; cycle2 save_en=6'b001000, save_byte=8'h5A, done=1; cycle3 instr_ready=1, copy_count=1.
- Instr 8'b10_110_010 with ext_in_byte=8'hC3 → load1_en=0 in READ; save_en=6'b000100, save_byte=8'hC3 in WRITE.
- Instr 8'b10_100_110 with reg4=8'h7E → ext_out_byte=8'h7E after the WRITE edge; ext_out_valid pulses one cycle; save_en stays 0.
- Illegal inputs 8'b00_000_001, 8'b10_111_000 and 8'b10_000_111 → illegal pulse each time, state stays IDLE, load1_en=save_en=0, copy_count unchanged.
- Valid held high for 256 legal copies → copy_count wraps to 0, throughput exactly one per 3 cycles, instr_ready low for 2 cycles per transfer.
- rst asserted mid-WRITE of 8'b10_001_000 → save_en drops immediately; reg0 unchanged; all outputs at reset values; next legal instruction accepted normally.
